// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the CPU port-I/O bridge.
//   intr_state_t : interrupt request FSM states
//   IO_DATA_W    : width of every port byte
//   IO_IDLE_BYTE : value presented on i_port when nothing is buffered
package io_bridge_pkg;

  localparam int unsigned IO_DATA_W = 8;
  localparam logic [IO_DATA_W-1:0] IO_IDLE_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SERVICE
  } intr_state_t;

endpackage

// File: rtl/io_rx_fifo.sv
// Synchronous receive FIFO feeding the CPU input port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop head entry (ignored when empty)
//   wdata_i    : byte to store
//   head_o     : oldest byte, IO_IDLE_BYTE when empty
//   count_o    : occupancy 0..DEPTH
//   full_o     : count == DEPTH
//   empty_o    : count == 0
module io_rx_fifo
  import io_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [IO_DATA_W-1:0]       wdata_i,
  output logic [IO_DATA_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [IO_DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = empty_o ? IO_IDLE_BYTE : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/io_port_bridge.sv
// Peripheral endpoint of the CPU port-I/O interface: buffers an external byte
// stream into the CPU input port, raises interrupt requests while bytes wait,
// and holds CPU output-port writes for an external valid/ready consumer.
// Build option: define IO_BRIDGE_INTR_EN to include the interrupt FSM;
// otherwise intr_sig is tied low and the CPU polls i_port.
// Ports:
//   clk, rst                                  : clock, sync active-high reset
//   ext_in_valid/ext_in_data/ext_in_ready     : producer handshake into FIFO
//   i_port, cpu_in_rd                         : FIFO head to CPU, CPU pop strobe
//   intr_sig                                  : interrupt request to CPU
//   o_port, cpu_out_we                        : CPU output byte and write strobe
//   ext_out_valid/ext_out_data/ext_out_ready  : consumer handshake out
//   rx_count                                  : FIFO occupancy
//   out_overrun                               : sticky lost-output-byte flag
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned INTR_LEN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_in_valid,
  input  logic [IO_DATA_W-1:0]   ext_in_data,
  output logic                   ext_in_ready,
  output logic [IO_DATA_W-1:0]   i_port,
  input  logic                   cpu_in_rd,
  output logic                   intr_sig,
  input  logic [IO_DATA_W-1:0]   o_port,
  input  logic                   cpu_out_we,
  output logic                   ext_out_valid,
  output logic [IO_DATA_W-1:0]   ext_out_data,
  input  logic                   ext_out_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   out_overrun
);

  logic fifo_full;
  logic fifo_empty;

  io_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (ext_in_valid),
    .pop_i  (cpu_in_rd),
    .wdata_i(ext_in_data),
    .head_o (i_port),
    .count_o(rx_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign ext_in_ready = ~fifo_full;

  // Transmit holding register.
  logic                 out_valid_q, out_valid_d;
  logic [IO_DATA_W-1:0] out_data_q, out_data_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;
    if (cpu_out_we) begin
      out_data_d  = o_port;
      out_valid_d = 1'b1;
      // A write in the same cycle as a completed handshake is not an overrun.
      if (out_valid_q && !ext_out_ready) overrun_d = 1'b1;
    end else if (out_valid_q && ext_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= IO_IDLE_BYTE;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ext_out_valid = out_valid_q;
  assign ext_out_data  = out_data_q;
  assign out_overrun   = overrun_q;

`ifdef IO_BRIDGE_INTR_EN
  localparam logic [3:0] IntrLen = 4'(INTR_LEN);

  intr_state_t state_q, state_d;
  logic [3:0]  pulse_cnt_q, pulse_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  // Leaving PULSE or SERVICE always passes through IDLE, which guarantees a
  // low cycle between consecutive requests.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d     = PULSE;
          pulse_cnt_d = IntrLen;
        end
      end
      PULSE: begin
        if (cpu_in_rd) begin
          state_d     = IDLE;
          pulse_cnt_d = '0;
        end else if (pulse_cnt_q == 4'd1) begin
          state_d     = SERVICE;
          pulse_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 4'd1;
        end
      end
      SERVICE: begin
        if (cpu_in_rd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    intr_sig = (state_q == PULSE);
  end
`else
  logic unused_intr_len;
  assign unused_intr_len = ^INTR_LEN;
  assign intr_sig        = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge (DEPTH=4, INTR_LEN=2): directed
// scenarios with literal expectations plus randomized traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_io_port_bridge;

  localparam int unsigned Depth   = 4;
  localparam int unsigned IntrLen = 2;
`ifdef IO_BRIDGE_INTR_EN
  localparam bit IntrEn = 1'b1;
`else
  localparam bit IntrEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ext_in_valid;
  logic [7:0] ext_in_data;
  logic       ext_in_ready;
  logic [7:0] i_port;
  logic       cpu_in_rd;
  logic       intr_sig;
  logic [7:0] o_port;
  logic       cpu_out_we;
  logic       ext_out_valid;
  logic [7:0] ext_out_data;
  logic       ext_out_ready;
  logic [2:0] rx_count;
  logic       out_overrun;

  io_port_bridge #(
    .DEPTH   (Depth),
    .INTR_LEN(IntrLen)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ext_in_valid (ext_in_valid),
    .ext_in_data  (ext_in_data),
    .ext_in_ready (ext_in_ready),
    .i_port       (i_port),
    .cpu_in_rd    (cpu_in_rd),
    .intr_sig     (intr_sig),
    .o_port       (o_port),
    .cpu_out_we   (cpu_out_we),
    .ext_out_valid(ext_out_valid),
    .ext_out_data (ext_out_data),
    .ext_out_ready(ext_out_ready),
    .rx_count     (rx_count),
    .out_overrun  (out_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte queue, output slot, and the interrupt described as
  // "high cycles still owed" plus "waiting for the CPU to read".
  logic [7:0] mq[$];
  bit         m_out_valid = 1'b0;
  logic [7:0] m_out_data  = 8'h00;
  bit         m_overrun   = 1'b0;
  int         m_high_left = 0;
  bit         m_waiting   = 1'b0;

  function automatic void model_step();
    int n;
    if (rst) begin
      mq.delete();
      m_out_valid = 1'b0;
      m_out_data  = 8'h00;
      m_overrun   = 1'b0;
      m_high_left = 0;
      m_waiting   = 1'b0;
      return;
    end
    n = mq.size();
    // Interrupt request decisions use the occupancy before this edge.
    if (m_high_left > 0) begin
      if (cpu_in_rd) m_high_left = 0;
      else begin
        m_high_left--;
        if (m_high_left == 0) m_waiting = 1'b1;
      end
    end else if (m_waiting) begin
      if (cpu_in_rd) m_waiting = 1'b0;
    end else if (n != 0) begin
      m_high_left = IntrLen;
    end
    // Output slot.
    if (cpu_out_we) begin
      if (m_out_valid && !ext_out_ready) m_overrun = 1'b1;
      m_out_valid = 1'b1;
      m_out_data  = o_port;
    end else if (m_out_valid && ext_out_ready) begin
      m_out_valid = 1'b0;
    end
    // Receive queue: push admission is judged against the old occupancy.
    if (cpu_in_rd && n > 0) void'(mq.pop_front());
    if (ext_in_valid && n < Depth) mq.push_back(ext_in_data);
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("rx_count", 32'(rx_count), 32'(mq.size()));
      chk("ext_in_ready", 32'(ext_in_ready), 32'(mq.size() != Depth));
      chk("i_port", 32'(i_port), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("intr_sig", 32'(intr_sig), 32'(IntrEn && (m_high_left > 0)));
      chk("ext_out_valid", 32'(ext_out_valid), 32'(m_out_valid));
      chk("ext_out_data", 32'(ext_out_data), 32'(m_out_data));
      chk("out_overrun", 32'(out_overrun), 32'(m_overrun));
    end
  end

  task automatic cycle(input logic v, input logic [7:0] d, input logic rd, input logic we,
                       input logic [7:0] op, input logic ordy, input logic r);
    @(negedge clk);
    ext_in_valid  = v;
    ext_in_data   = d;
    cpu_in_rd     = rd;
    cpu_out_we    = we;
    o_port        = op;
    ext_out_ready = ordy;
    rst           = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic [7:0] bytes4 [4];
  logic       intr_exp [4];

  initial begin
    ext_in_valid = 1'b0; ext_in_data = 8'h00; cpu_in_rd = 1'b0; cpu_out_we = 1'b0;
    o_port = 8'h00; ext_out_ready = 1'b0; rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_en = 1'b1;

    // Reset state.
    chk("rst rx_count", 32'(rx_count), 32'd0);
    chk("rst ready", 32'(ext_in_ready), 32'd1);
    chk("rst i_port", 32'(i_port), 32'h00);
    chk("rst intr", 32'(intr_sig), 32'd0);
    chk("rst out_valid", 32'(ext_out_valid), 32'd0);
    chk("rst out_data", 32'(ext_out_data), 32'h00);
    chk("rst overrun", 32'(out_overrun), 32'd0);

    // Single push: visible next cycle, interrupt high two cycles starting two later.
    intr_exp = '{1'b0, IntrEn, IntrEn, 1'b0};
    push(8'hA5);
    chk("a5 i_port", 32'(i_port), 32'hA5);
    chk("a5 rx_count", 32'(rx_count), 32'd1);
    chk("a5 intr0", 32'(intr_sig), 32'(intr_exp[0]));
    for (int i = 1; i < 4; i++) begin
      idle();
      chk($sformatf("a5 intr%0d", i), 32'(intr_sig), 32'(intr_exp[i]));
    end
    pop();
    chk("a5 drained", 32'(rx_count), 32'd0);

    // Fill to capacity, refused fifth push, in-order drain, pop on empty.
    bytes4 = '{8'h01, 8'h82, 8'h43, 8'hC4};
    for (int i = 0; i < 4; i++) push(bytes4[i]);
    chk("full ready", 32'(ext_in_ready), 32'd0);
    chk("full count", 32'(rx_count), 32'd4);
    push(8'h55);
    chk("5th push count", 32'(rx_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain head%0d", i), 32'(i_port), 32'(bytes4[i]));
      pop();
    end
    pop();
    chk("empty pop i_port", 32'(i_port), 32'h00);
    chk("empty pop count", 32'(rx_count), 32'd0);

    // Simultaneous push and pop with two entries, then wrap-around pairs.
    push(8'h21);
    push(8'h22);
    cycle(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pp count", 32'(rx_count), 32'd2);
    chk("pp head", 32'(i_port), 32'h22);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap count", 32'(rx_count), 32'd2);
    pop();
    pop();
    chk("wrap drained", 32'(rx_count), 32'd0);

    // Output overrun.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("tx first", 32'(ext_out_data), 32'h3C);
    chk("tx no overrun", 32'(out_overrun), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
    chk("tx data", 32'(ext_out_data), 32'h7E);
    chk("tx overrun", 32'(out_overrun), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("tx drained", 32'(ext_out_valid), 32'd0);
    chk("tx overrun sticky", 32'(out_overrun), 32'd1);

    // Pop during SERVICE gives one low cycle, then a new pulse; reset mid-pulse.
    push(8'h31);
    push(8'h32);
    idle();
    idle();
    idle();
    pop();
    chk("svc pop intr", 32'(intr_sig), 32'd0);
    chk("svc pop head", 32'(i_port), 32'h32);
    idle();
    chk("svc repulse", 32'(intr_sig), 32'(IntrEn));
    idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("midrst intr", 32'(intr_sig), 32'd0);
    chk("midrst count", 32'(rx_count), 32'd0);
    chk("midrst i_port", 32'(i_port), 32'h00);
    chk("midrst overrun", 32'(out_overrun), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(1, 0)), 8'($urandom), ($urandom_range(2, 0) == 0),
            ($urandom_range(3, 0) == 0), 8'($urandom), 1'($urandom_range(1, 0)),
            ($urandom_range(99, 0) == 0));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
